hazard_scoreboard_unit: RTL and testbench

Next-generation forwarding and hazard unit for the five-stage RV32 pipeline. It keeps the existing EX/MEM and MEM/WB operand forwarding, the load→store data forward, and the load-use stall. It adds a per-register busy scoreboard for variable-latency long operations (divider, multi-cycle memory) that complete out of band, with a dedicated forward path from their result bus. It also adds an outstanding-op limit and a saturating stall-cycle counter. It sits beside the ID/EX pipeline registers and drives the operand muxes and the IF/ID hold.

---
 rtl/hazard_scoreboard_unit_if.sv | 63 ++++++
 rtl/hazard_scoreboard_unit.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM/WB fields and long-op completion in, operand selects and hold out.
// The pipeline side uses the master modport and hazard_scoreboard_unit uses the slave modport.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic              id_reg_w_ena_i;
    logic              id_long_i;
    logic              id_valid_i;

    logic [REG_AW-1:0] ex_rs1_i;
    logic [REG_AW-1:0] ex_rs2_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_valid_i;
    logic              ex_reg_w_ena_i;
    logic              ex_ram_r_i;
    logic              ex_ram_w_ena_i;
    logic              ex_long_i;

    logic [REG_AW-1:0] mem_rd_i;
    logic              mem_reg_w_ena_i;
    logic              mem_ram_r_i;

    logic [REG_AW-1:0] wb_rd_i;
    logic              wb_reg_w_ena_i;

    logic              long_done_i;
    logic [REG_AW-1:0] long_rd_i;

    logic [1:0]        forwardA_o;
    logic [1:0]        forwardB_o;
    logic              forwardC_o;
    logic              hazard_hold_o;
    logic              busy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
               id_reg_w_ena_i, id_long_i, id_valid_i,
               ex_rs1_i, ex_rs2_i, ex_rd_i, ex_valid_i, ex_reg_w_ena_i,
               ex_ram_r_i, ex_ram_w_ena_i, ex_long_i,
               mem_rd_i, mem_reg_w_ena_i, mem_ram_r_i,
               wb_rd_i, wb_reg_w_ena_i,
               long_done_i, long_rd_i,
        input  forwardA_o, forwardB_o, forwardC_o, hazard_hold_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
               id_reg_w_ena_i, id_long_i, id_valid_i,
               ex_rs1_i, ex_rs2_i, ex_rd_i, ex_valid_i, ex_reg_w_ena_i,
               ex_ram_r_i, ex_ram_w_ena_i, ex_long_i,
               mem_rd_i, mem_reg_w_ena_i, mem_ram_r_i,
               wb_rd_i, wb_reg_w_ena_i,
               long_done_i, long_rd_i,
        output forwardA_o, forwardB_o, forwardC_o, hazard_hold_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// RV32 forwarding/hazard unit with a long-op busy scoreboard. Selects and hold are zero-latency; state is registered.
// Backpressure: hazard_hold_o freezes PC and IF/ID and bubbles ID/EX; nothing is queued internally.
module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int MAX_LONG = 4,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  bus
);
    localparam int NREG = 1 << REG_AW;
    localparam int OW   = $clog2(MAX_LONG + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_LONG);

    logic [NREG-1:0]  r_busy;
    logic [OW-1:0]    r_outstanding;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [NREG-1:0]  w_clr_mask;
    logic [NREG-1:0]  w_set_mask;
    logic [NREG-1:0]  w_busy_eff;
    logic             w_ex_load;
    logic             w_id_store;
    logic             w_load_use;
    logic             w_raw;
    logic             w_waw;
    logic             w_cap;
    logic             w_hold;
    logic             w_issue;
    logic             w_retire;

    // Youngest producer wins: EX/MEM, then MEM/WB, then the long-op result bus.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] mem_rd,
        input logic [REG_AW-1:0] wb_rd,
        input logic [REG_AW-1:0] long_rd,
        input logic              mem_w,
        input logic              wb_w,
        input logic              long_done
    );
        logic [1:0] sel;
        if (mem_w && (mem_rd != '0) && (mem_rd == rs))
            sel = 2'b10;
        else if (wb_w && (wb_rd != '0) && (wb_rd == rs))
            sel = 2'b01;
        else if (long_done && (long_rd != '0) && (long_rd == rs))
            sel = 2'b11;
        else
            sel = 2'b00;
        return sel;
    endfunction

    assign bus.forwardA_o = fwd_sel(bus.ex_rs1_i, bus.mem_rd_i, bus.wb_rd_i, bus.long_rd_i,
                                    bus.mem_reg_w_ena_i, bus.wb_reg_w_ena_i, bus.long_done_i);
    assign bus.forwardB_o = fwd_sel(bus.ex_rs2_i, bus.mem_rd_i, bus.wb_rd_i, bus.long_rd_i,
                                    bus.mem_reg_w_ena_i, bus.wb_reg_w_ena_i, bus.long_done_i);

    assign bus.forwardC_o = bus.mem_reg_w_ena_i && bus.mem_ram_r_i && (bus.mem_rd_i != '0) &&
                            (bus.mem_rd_i != bus.ex_rs1_i) && (bus.mem_rd_i == bus.ex_rs2_i) &&
                            bus.ex_ram_w_ena_i;

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (bus.long_done_i)
            w_clr_mask[bus.long_rd_i] = 1'b1;
        if (bus.ex_valid_i && bus.ex_long_i && bus.ex_reg_w_ena_i && (bus.ex_rd_i != '0))
            w_set_mask[bus.ex_rd_i] = 1'b1;
    end

    // A completing register is already readable through the 11 forward path.
    assign w_busy_eff = r_busy & ~w_clr_mask;

    assign w_ex_load = bus.ex_valid_i && bus.ex_ram_r_i && bus.ex_reg_w_ena_i && (bus.ex_rd_i != '0);

    // No store flag reaches ID: a store is recognised as reading both sources without a register write.
    assign w_id_store = bus.id_rs1_used_i && bus.id_rs2_used_i && !bus.id_reg_w_ena_i;

    assign w_load_use = w_ex_load &&
                        ((bus.id_rs1_used_i && (bus.ex_rd_i == bus.id_rs1_i)) ||
                         (!w_id_store && bus.id_rs2_used_i && (bus.ex_rd_i == bus.id_rs2_i)));

    assign w_raw = (bus.id_rs1_used_i && w_busy_eff[bus.id_rs1_i]) ||
                   (bus.id_rs2_used_i && w_busy_eff[bus.id_rs2_i]);

    assign w_waw = bus.id_reg_w_ena_i && w_busy_eff[bus.id_rd_i];

    assign w_cap = bus.id_long_i && (r_outstanding == OUT_MAX) && !bus.long_done_i;

    assign w_hold = bus.id_valid_i && (w_load_use || w_raw || w_waw || w_cap);

    assign w_issue  = bus.ex_valid_i && bus.ex_long_i;
    // A completion with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
    assign w_retire = bus.long_done_i && (r_outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            case ({w_issue, w_retire})
                2'b10: begin
                    if (r_outstanding != OUT_MAX)
                        r_outstanding <= r_outstanding + OW'(1);
                end
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_hold && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.hazard_hold_o = w_hold;
    assign bus.busy_o        = |r_busy;
    assign bus.stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed pipeline scenarios plus random traffic against a behavioural model.
module tb_hazard_scoreboard_unit;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(32)) bus ();

    hazard_scoreboard_unit #(.REG_AW(5), .MAX_LONG(MAXL), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: which registers await a long result, how many long ops are in flight, stall cycles seen.
    bit          m_busy [32];
    int          m_out = 0;
    logic [31:0] m_cnt = '0;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        fc;
        logic        hold;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (bus.mem_reg_w_ena_i && bus.mem_rd_i != 0 && bus.mem_rd_i == rs) return 2'b10;
        if (bus.wb_reg_w_ena_i && bus.wb_rd_i != 0 && bus.wb_rd_i == rs) return 2'b01;
        if (bus.long_done_i && bus.long_rd_i != 0 && bus.long_rd_i == rs) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit m_waiting(input logic [4:0] r);
        return m_busy[r] && !(bus.long_done_i && bus.long_rd_i == r);
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        bit is_store, ld, lu, raw, waw, cap;
        e.fa = m_fwd(bus.ex_rs1_i);
        e.fb = m_fwd(bus.ex_rs2_i);
        e.fc = bus.mem_reg_w_ena_i && bus.mem_ram_r_i && bus.mem_rd_i != 0 &&
               bus.mem_rd_i != bus.ex_rs1_i && bus.mem_rd_i == bus.ex_rs2_i && bus.ex_ram_w_ena_i;
        is_store = bus.id_rs1_used_i && bus.id_rs2_used_i && !bus.id_reg_w_ena_i;
        ld  = bus.ex_valid_i && bus.ex_ram_r_i && bus.ex_reg_w_ena_i && bus.ex_rd_i != 0;
        lu  = ld && ((bus.id_rs1_used_i && bus.ex_rd_i == bus.id_rs1_i) ||
                     (!is_store && bus.id_rs2_used_i && bus.ex_rd_i == bus.id_rs2_i));
        raw = (bus.id_rs1_used_i && m_waiting(bus.id_rs1_i)) || (bus.id_rs2_used_i && m_waiting(bus.id_rs2_i));
        waw = bus.id_reg_w_ena_i && m_waiting(bus.id_rd_i);
        cap = bus.id_long_i && m_out == MAXL && !bus.long_done_i;
        e.hold = bus.id_valid_i && (lu || raw || waw || cap);
        e.busy = 1'b0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) e.busy = 1'b1;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic model_commit(input logic hold);
        int n;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_out = 0;
            m_cnt = '0;
            return;
        end
        if (hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (bus.long_done_i) m_busy[bus.long_rd_i] = 1'b0;
        if (bus.ex_valid_i && bus.ex_long_i && bus.ex_reg_w_ena_i && bus.ex_rd_i != 0)
            m_busy[bus.ex_rd_i] = 1'b1;
        n = m_out;
        if (bus.ex_valid_i && bus.ex_long_i) n = n + 1;
        if (bus.long_done_i && m_out > 0) n = n - 1;
        m_out = (n > MAXL) ? MAXL : n;
    endtask

    task automatic tick();
        exp_t e;
        e = model_eval();
        @(posedge clk);
        model_commit(e.hold);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_rd_i = '0;
        bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0; bus.id_reg_w_ena_i = 0;
        bus.id_long_i = 0; bus.id_valid_i = 0;
        bus.ex_rs1_i = '0; bus.ex_rs2_i = '0; bus.ex_rd_i = '0;
        bus.ex_valid_i = 0; bus.ex_reg_w_ena_i = 0; bus.ex_ram_r_i = 0;
        bus.ex_ram_w_ena_i = 0; bus.ex_long_i = 0;
        bus.mem_rd_i = '0; bus.mem_reg_w_ena_i = 0; bus.mem_ram_r_i = 0;
        bus.wb_rd_i = '0; bus.wb_reg_w_ena_i = 0;
        bus.long_done_i = 0; bus.long_rd_i = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic ex_long_op(input logic [4:0] rd);
        bus.ex_valid_i = 1; bus.ex_long_i = 1; bus.ex_reg_w_ena_i = 1; bus.ex_rd_i = rd;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.forwardB_o, bus.forwardC_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_fwd: got %b expected 00000", {bus.forwardA_o, bus.forwardB_o, bus.forwardC_o});
        end
        tests_run++;
        if ({bus.hazard_hold_o, bus.busy_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_hold_busy: got %b expected 00", {bus.hazard_hold_o, bus.busy_o});
        end
        tests_run++;
        if (bus.stall_cnt_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt_o);
        end
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        bus.ex_rs1_i = 5; bus.ex_rs2_i = 6;
        bus.mem_reg_w_ena_i = 1; bus.mem_ram_r_i = 1; bus.mem_rd_i = 5;
        bus.wb_reg_w_ena_i = 1; bus.wb_rd_i = 5;
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.forwardB_o} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL fwd_mem_prio: got A=%b B=%b expected A=10 B=00", bus.forwardA_o, bus.forwardB_o);
        end
        tick();
        bus.mem_reg_w_ena_i = 0;
        #1;
        tests_run++;
        if (bus.forwardA_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwd_wb: got %b expected 01", bus.forwardA_o);
        end
        tick();
        bus.wb_reg_w_ena_i = 0; bus.long_done_i = 1; bus.long_rd_i = 5; bus.ex_rs2_i = 5;
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.forwardB_o} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL fwd_long: got A=%b B=%b expected A=11 B=11", bus.forwardA_o, bus.forwardB_o);
        end
        tick();
        bus.mem_reg_w_ena_i = 1; bus.mem_rd_i = 0; bus.wb_reg_w_ena_i = 1; bus.wb_rd_i = 0;
        bus.long_rd_i = 0; bus.ex_rs1_i = 0; bus.ex_rs2_i = 0;
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.forwardB_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL fwd_x0: got A=%b B=%b expected A=00 B=00", bus.forwardA_o, bus.forwardB_o);
        end
        tick();
        bus.long_done_i = 0; bus.mem_rd_i = 6; bus.wb_rd_i = 6; bus.ex_rs2_i = 6;
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.forwardB_o} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fwd_b_prio: got A=%b B=%b expected A=00 B=10", bus.forwardA_o, bus.forwardB_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_valid_i = 1; bus.ex_ram_r_i = 1; bus.ex_reg_w_ena_i = 1; bus.ex_rd_i = 3;
        bus.id_valid_i = 1; bus.id_rs1_i = 3; bus.id_rs1_used_i = 1; bus.id_rs2_i = 1;
        bus.id_rs2_used_i = 1; bus.id_reg_w_ena_i = 1; bus.id_rd_i = 4;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_hold: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
        bus.ex_valid_i = 0; bus.ex_ram_r_i = 0; bus.ex_reg_w_ena_i = 0; bus.ex_rd_i = 0;
        bus.mem_rd_i = 3; bus.mem_reg_w_ena_i = 1; bus.mem_ram_r_i = 1;
        #1;
        tests_run++;
        if ({bus.hazard_hold_o, bus.stall_cnt_o} !== {1'b0, 32'd1}) begin
            tests_failed++;
            $display("FAIL lu_release: got hold=%b cnt=%0d expected hold=0 cnt=1", bus.hazard_hold_o, bus.stall_cnt_o);
        end
        tick();
        // sw x3,0(x2) behind lw x3: data operand only, no stall.
        drive_idle();
        bus.ex_valid_i = 1; bus.ex_ram_r_i = 1; bus.ex_reg_w_ena_i = 1; bus.ex_rd_i = 3;
        bus.id_valid_i = 1; bus.id_rs1_i = 2; bus.id_rs1_used_i = 1; bus.id_rs2_i = 3; bus.id_rs2_used_i = 1;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_store_nohold: got %b expected 0", bus.hazard_hold_o);
        end
        tick();
        drive_idle();
        bus.ex_valid_i = 1; bus.ex_ram_w_ena_i = 1; bus.ex_rs1_i = 2; bus.ex_rs2_i = 3;
        bus.mem_rd_i = 3; bus.mem_reg_w_ena_i = 1; bus.mem_ram_r_i = 1;
        #1;
        tests_run++;
        if ({bus.forwardC_o, bus.stall_cnt_o} !== {1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL fwd_c: got fc=%b cnt=%0d expected fc=1 cnt=1", bus.forwardC_o, bus.stall_cnt_o);
        end
        bus.ex_rs1_i = 3;
        #1;
        tests_run++;
        if (bus.forwardC_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_c_base: got %b expected 0", bus.forwardC_o);
        end
        tick();
        // sw x5,0(x3) behind lw x3: base address needed, must stall.
        drive_idle();
        bus.ex_valid_i = 1; bus.ex_ram_r_i = 1; bus.ex_reg_w_ena_i = 1; bus.ex_rd_i = 3;
        bus.id_valid_i = 1; bus.id_rs1_i = 3; bus.id_rs1_used_i = 1; bus.id_rs2_i = 5; bus.id_rs2_used_i = 1;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_store_base: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
    endtask

    task automatic test_long_raw();
        do_reset();
        ex_long_op(7);
        bus.id_valid_i = 1; bus.id_rs1_i = 7; bus.id_rs1_used_i = 1; bus.id_reg_w_ena_i = 1; bus.id_rd_i = 8;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_issue_cycle: got %b expected 0", bus.hazard_hold_o);
        end
        tick();
        bus.ex_valid_i = 0; bus.ex_long_i = 0; bus.ex_reg_w_ena_i = 0; bus.ex_rd_i = 0;
        #1;
        tests_run++;
        if ({bus.hazard_hold_o, bus.busy_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL raw_hold: got hold,busy=%b expected 11", {bus.hazard_hold_o, bus.busy_o});
        end
        tick();
        tick();
        bus.long_done_i = 1; bus.long_rd_i = 7; bus.ex_rs1_i = 7;
        #1;
        tests_run++;
        if ({bus.hazard_hold_o, bus.forwardA_o} !== 3'b011) begin
            tests_failed++;
            $display("FAIL raw_bypass: got hold=%b fa=%b expected hold=0 fa=11", bus.hazard_hold_o, bus.forwardA_o);
        end
        tick();
        drive_idle();
        bus.ex_valid_i = 1; bus.ex_rs1_i = 7; bus.ex_reg_w_ena_i = 1; bus.ex_rd_i = 8;
        #1;
        tests_run++;
        if ({bus.forwardA_o, bus.busy_o, bus.stall_cnt_o} !== {2'b00, 1'b0, 32'd2}) begin
            tests_failed++;
            $display("FAIL raw_after: got fa=%b busy=%b cnt=%0d expected fa=00 busy=0 cnt=2",
                     bus.forwardA_o, bus.busy_o, bus.stall_cnt_o);
        end
        tick();
    endtask

    task automatic test_capacity();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ex_long_op(5'(11 + k));
            tick();
        end
        drive_idle();
        bus.id_valid_i = 1; bus.id_long_i = 1; bus.id_reg_w_ena_i = 1; bus.id_rd_i = 20;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL cap_full: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
        bus.long_done_i = 1; bus.long_rd_i = 12;
        ex_long_op(15);
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL cap_done_release: got %b expected 0", bus.hazard_hold_o);
        end
        tick();
        bus.long_done_i = 0; bus.long_rd_i = 0;
        bus.ex_valid_i = 0; bus.ex_long_i = 0; bus.ex_reg_w_ena_i = 0; bus.ex_rd_i = 0;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL cap_still_full: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
    endtask

    task automatic test_waw_collision();
        do_reset();
        ex_long_op(9);
        tick();
        drive_idle();
        bus.id_valid_i = 1; bus.id_reg_w_ena_i = 1; bus.id_rd_i = 9;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL waw_hold: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
        bus.long_done_i = 1; bus.long_rd_i = 9;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_bypass: got %b expected 0", bus.hazard_hold_o);
        end
        tick();
        drive_idle();
        ex_long_op(10);
        tick();
        bus.long_done_i = 1; bus.long_rd_i = 10;
        tick();
        drive_idle();
        bus.id_valid_i = 1; bus.id_rs1_i = 10; bus.id_rs1_used_i = 1;
        #1;
        tests_run++;
        if ({bus.hazard_hold_o, bus.busy_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL set_wins: got hold,busy=%b expected 11", {bus.hazard_hold_o, bus.busy_o});
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.id_valid_i = 1; bus.id_rs1_i = 1; bus.id_rs1_used_i = 1;
        for (int k = 1; k <= 3; k++) begin
            ex_long_op(5'(k));
            tick();
        end
        drive_idle();
        #1;
        tests_run++;
        if ({bus.busy_o, bus.stall_cnt_o} !== {1'b1, 32'd2}) begin
            tests_failed++;
            $display("FAIL mid_before: got busy=%b cnt=%0d expected busy=1 cnt=2", bus.busy_o, bus.stall_cnt_o);
        end
        do_reset();
        #1;
        tests_run++;
        if ({bus.busy_o, bus.stall_cnt_o} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL mid_reset: got busy=%b cnt=%0d expected busy=0 cnt=0", bus.busy_o, bus.stall_cnt_o);
        end
        bus.long_done_i = 1; bus.long_rd_i = 2;
        tick();
        drive_idle();
        for (int k = 4; k <= 6; k++) begin
            ex_long_op(5'(k));
            tick();
        end
        drive_idle();
        bus.id_valid_i = 1; bus.id_long_i = 1;
        #1;
        tests_run++;
        if ({bus.hazard_hold_o, bus.stall_cnt_o} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL stale_done_three: got hold=%b cnt=%0d expected hold=0 cnt=0", bus.hazard_hold_o, bus.stall_cnt_o);
        end
        ex_long_op(7);
        tick();
        bus.ex_valid_i = 0; bus.ex_long_i = 0; bus.ex_reg_w_ena_i = 0; bus.ex_rd_i = 0;
        #1;
        tests_run++;
        if (bus.hazard_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL stale_done_four: got %b expected 1", bus.hazard_hold_o);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int q[$];
            q.delete();
            rst = ($urandom_range(0, 149) == 0);
            bus.id_valid_i     = 1'($urandom_range(0, 1));
            bus.id_rs1_i       = 5'($urandom_range(0, 7));
            bus.id_rs2_i       = 5'($urandom_range(0, 7));
            bus.id_rd_i        = 5'($urandom_range(0, 7));
            bus.id_rs1_used_i  = 1'($urandom_range(0, 1));
            bus.id_rs2_used_i  = 1'($urandom_range(0, 1));
            bus.id_reg_w_ena_i = 1'($urandom_range(0, 1));
            bus.id_long_i      = ($urandom_range(0, 2) == 0);
            bus.ex_rs1_i       = 5'($urandom_range(0, 7));
            bus.ex_rs2_i       = 5'($urandom_range(0, 7));
            bus.ex_rd_i        = 5'($urandom_range(0, 7));
            bus.ex_valid_i     = ($urandom_range(0, 3) != 0);
            bus.ex_reg_w_ena_i = 1'($urandom_range(0, 1));
            bus.ex_ram_r_i     = ($urandom_range(0, 2) == 0);
            bus.ex_ram_w_ena_i = ($urandom_range(0, 2) == 0);
            bus.ex_long_i      = ($urandom_range(0, 2) == 0);
            bus.mem_rd_i       = 5'($urandom_range(0, 7));
            bus.mem_reg_w_ena_i = 1'($urandom_range(0, 1));
            bus.mem_ram_r_i    = 1'($urandom_range(0, 1));
            bus.wb_rd_i        = 5'($urandom_range(0, 7));
            bus.wb_reg_w_ena_i = 1'($urandom_range(0, 1));
            bus.long_done_i    = ($urandom_range(0, 3) == 0);
            for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                bus.long_rd_i = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.long_rd_i = 5'($urandom_range(0, 7));
            #1;
            e = model_eval();
            tests_run++;
            if ({bus.forwardA_o, bus.forwardB_o, bus.forwardC_o, bus.hazard_hold_o, bus.busy_o, bus.stall_cnt_o} !== e) begin
                tests_failed++;
                $display("FAIL random[%0d]: got fa=%b fb=%b fc=%b hold=%b busy=%b cnt=%0d expected fa=%b fb=%b fc=%b hold=%b busy=%b cnt=%0d",
                         i, bus.forwardA_o, bus.forwardB_o, bus.forwardC_o, bus.hazard_hold_o, bus.busy_o, bus.stall_cnt_o,
                         e.fa, e.fb, e.fc, e.hold, e.busy, e.cnt);
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_forward();
        test_load_use();
        test_long_raw();
        test_capacity();
        test_waw_collision();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
